serial_subtractor: RTL

- Multi-cycle, bit-serial 8-bit subtractor.
- Computes operand_1 - operand_2 LSB-first, one bit per clock, through a one-bit full-subtractor cell.
- Returns the difference and the final borrow with a start/busy/done handshake.
- Partner to the team's combinational fulladder. Used in the neuron datapath where area matters more than latency, e.g. bias/threshold subtraction.

---
 rtl/sub_pkg.sv | 14 +
 rtl/serial_subtractor_if.sv | 34 +++
 rtl/full_subtractor_1b.sv | 13 +
 rtl/serial_subtractor.sv | 99 +++++++++
 4 files changed

// File: rtl/sub_pkg.sv
// Shared constants for the bit-serial subtractor: FSM state encoding and default width.
package sub_pkg;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RUN  = 1'b1;

  localparam int unsigned DEFAULT_WIDTH = 8;

  typedef enum logic {
    StIdle = ST_IDLE,
    StRun  = ST_RUN
  } state_e;

endpackage

// File: rtl/serial_subtractor_if.sv
// Handshake and data bundle for serial_subtractor; the requester uses master, the subtractor slave.
interface serial_subtractor_if #(
  parameter int unsigned WIDTH = sub_pkg::DEFAULT_WIDTH
);

  logic             start;
  logic [WIDTH-1:0] operand_1;
  logic [WIDTH-1:0] operand_2;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             bo;

  modport master (
    output start,
    output operand_1,
    output operand_2,
    input  busy,
    input  done,
    input  result,
    input  bo
  );

  modport slave (
    input  start,
    input  operand_1,
    input  operand_2,
    output busy,
    output done,
    output result,
    output bo
  );

endinterface

// File: rtl/full_subtractor_1b.sv
// One-bit full subtractor cell: d = a - b - bin, bout set when the bit borrows.
module full_subtractor_1b (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, LSB first, one bit per clock with start/busy/done handshake.
// Define SERIAL_SUBTRACTOR_SATURATE_EN to clamp a borrowing result to zero.
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input logic                clk,
  input logic                rst_n,
  serial_subtractor_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LastBit = CNT_W'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  // Holds the WIDTH-1 low difference bits; the MSB joins them on the final step.
  logic [WIDTH-2:0] diff_q;
  logic             br_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] result_q;
  logic             bo_q;

  logic             bit_d;
  logic             bit_bout;
  logic [WIDTH-1:0] diff_full;
  logic [WIDTH-1:0] final_result;

  full_subtractor_1b u_cell (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (br_q),
    .d    (bit_d),
    .bout (bit_bout)
  );

  assign diff_full = {bit_d, diff_q};

`ifdef SERIAL_SUBTRACTOR_SATURATE_EN
  assign final_result = bit_bout ? '0 : diff_full;
`else
  assign final_result = diff_full;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      br_q     <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      bo_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            a_q     <= bus.operand_1;
            b_q     <= bus.operand_2;
            diff_q  <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StRun;
          end
        end
        StRun: begin
          a_q    <= a_q >> 1;
          b_q    <= b_q >> 1;
          diff_q <= diff_full[WIDTH-1:1];
          br_q   <= bit_bout;
          cnt_q  <= cnt_q + CNT_W'(1);
          if (cnt_q == LastBit) begin
            result_q <= final_result;
            bo_q     <= bit_bout;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.bo     = bo_q;

endmodule
